// File: rtl/shift_reg_seq_pkg.sv
// rtl/shift_reg_seq_pkg.sv - shared types and constants for the shift register sequencer
package shift_reg_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic OP_LOAD   = 1'b0;
    localparam logic OP_SHIFT  = 1'b1;
    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/shift_reg_sequencer_if.sv
// rtl/shift_reg_sequencer_if.sv - command/response handshake bundle for the sequencer
//   master: host side (drives cmd_*, rsp_ready)
//   slave : sequencer side (drives cmd_ready, rsp_valid, rsp_data)
interface shift_reg_sequencer_if
    import shift_reg_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_op;
    logic             cmd_dir;
    logic [WIDTH-1:0] cmd_data;
    logic [CNT_W-1:0] cmd_count;
    logic             cmd_fill;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;

    modport master (
        output cmd_valid, cmd_op, cmd_dir, cmd_data, cmd_count, cmd_fill, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_dir, cmd_data, cmd_count, cmd_fill, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/bidir_shift_reg.sv
// rtl/bidir_shift_reg.sv - parameterised bidirectional serial-in shift register
//   clk, rstn (sync active-low clear), d serial in, en shift enable,
//   dir 0 = left (d into bit 0), 1 = right (d into bit MSB-1), out parallel contents
module bidir_shift_reg #(
    parameter int MSB = 8
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           d,
    input  logic           en,
    input  logic           dir,
    output logic [MSB-1:0] out
);
    always_ff @(posedge clk) begin
        if (!rstn) begin
            out <= '0;
        end else if (en) begin
            if (dir) begin
                out <= {d, out[MSB-1:1]};
            end else begin
                out <= {out[MSB-2:0], d};
            end
        end
    end
endmodule

// File: rtl/shift_reg_sequencer.sv
// rtl/shift_reg_sequencer.sv - command-driven LOAD/SHIFT sequencer for a bidirectional shift register
//   clk, rst         : clock, asynchronous active-high reset
//   bus (slave)      : cmd valid/ready with op/dir/data/count/fill; rsp valid/ready with data
//   sr_d/sr_en/sr_dir: registered drive to the shift register
//   sr_out           : shift register contents, returned as rsp_data
//   busy             : high whenever not IDLE
module shift_reg_sequencer
    import shift_reg_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    shift_reg_sequencer_if.slave bus,
    output logic                 sr_d,
    output logic                 sr_en,
    output logic                 sr_dir,
    input  logic [WIDTH-1:0]     sr_out,
    output logic                 busy
);
    // Wide enough for both a full LOAD (WIDTH) and any SHIFT count.
    localparam int CW = max_int($clog2(WIDTH + 1), CNT_W);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] pend_q;      // LOAD bits still to be presented on sr_d
    logic             accept;
    logic             last;

    assign bus.cmd_ready = (state_q == IDLE);
    assign bus.rsp_data  = sr_out;
    assign busy          = (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        last    = (cnt_q == CW'(1));
        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    accept = 1'b1;
                    if (bus.cmd_op == OP_LOAD) begin
                        state_d = LOAD;
                    end else if (bus.cmd_count != '0) begin
                        state_d = SHIFT;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            LOAD, SHIFT: begin
                if (last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            pend_q        <= '0;
            sr_d          <= 1'b0;
            sr_en         <= 1'b0;
            sr_dir        <= 1'b0;
            bus.rsp_valid <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (state_d == DONE) begin
                            // Zero-count SHIFT: answer immediately, leave sr_dir alone.
                            bus.rsp_valid <= 1'b1;
                        end else begin
                            sr_en  <= 1'b1;
                            sr_dir <= bus.cmd_dir;
                            if (bus.cmd_op == OP_LOAD) begin
                                cnt_q <= CW'(WIDTH);
                                // The bit entering first ends up furthest from the entry end.
                                if (bus.cmd_dir == DIR_LEFT) begin
                                    sr_d   <= bus.cmd_data[WIDTH-1];
                                    pend_q <= bus.cmd_data << 1;
                                end else begin
                                    sr_d   <= bus.cmd_data[0];
                                    pend_q <= bus.cmd_data >> 1;
                                end
                            end else begin
                                cnt_q <= CW'(bus.cmd_count);
                                sr_d  <= bus.cmd_fill;
                            end
                        end
                    end
                end
                LOAD: begin
                    if (last) begin
                        sr_en         <= 1'b0;
                        sr_d          <= 1'b0;
                        bus.rsp_valid <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                        if (sr_dir == DIR_LEFT) begin
                            sr_d   <= pend_q[WIDTH-1];
                            pend_q <= pend_q << 1;
                        end else begin
                            sr_d   <= pend_q[0];
                            pend_q <= pend_q >> 1;
                        end
                    end
                end
                SHIFT: begin
                    if (last) begin
                        sr_en         <= 1'b0;
                        sr_d          <= 1'b0;
                        bus.rsp_valid <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                DONE: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
